load_store_unit: RTL and testbench

Multi-cycle data-memory access engine directly downstream of the main controller's MEMORY state. It consumes the controller's DMemWrite and memRead strobes, funct3, and the ALU-computed address. It drives a word-wide valid/ready data-memory bus with byte enables, then returns sign- or zero-extended load data for the WRITEBACK path. Status outputs (busy/done/accessError) let the controller hold in MEMORY until the access completes.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Word-wide valid/ready handshake with byte enables.
`timescale 1ns/1ps
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns the controller's one-cycle load/store strobes into a
// valid/ready data-memory transaction, then reports done/accessError and
// returns the sign- or zero-extended load result for writeback.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRead,
  input  logic                  DMemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           storeData,
  load_store_unit_if.master     bus,
  output logic [31:0]           loadData,
  output logic                  busy,
  output logic                  done,
  output logic                  accessError
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  is_load_q, is_load_d;

  logic                  start;
  logic                  start_store;
  logic                  illegal;
  logic                  misaligned;
  logic [3:0]            be_calc;
  logic [31:0]           wdata_calc;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           ext_data;

  // A store wins when both strobes arrive together.
  assign start       = DMemWrite | memRead;
  assign start_store = DMemWrite;

  assign illegal = start_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                               : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));

  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign byte_sel = bus.mem_rdata[8*addr_lo_q +: 8];
  assign half_sel = bus.mem_rdata[16*addr_lo_q[1] +: 16];

  // Byte-enable and lane-replicated write data for the access being started.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = storeData;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{storeData[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{storeData[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = storeData;
      end
    endcase
  end

  // Extract and extend the addressed lane of the returned read word.
  always_comb begin
    ext_data = bus.mem_rdata;
    case (funct3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'b0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'b0, half_sel};
      default: ext_data = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    is_load_d   = is_load_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d    = funct3;
          addr_lo_d   = addr[1:0];
          is_load_d   = !start_store;
          mem_we_d    = start_store;
          mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_d    = be_calc;
          mem_wdata_d = start_store ? wdata_calc : 32'h0;
          cnt_d       = 8'd0;
          busy_d      = 1'b1;
          if (illegal || misaligned) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (is_load_q) begin
            load_data_d = ext_data;
          end
        end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          mem_req_d = 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      funct3_q    <= 3'b0;
      addr_lo_q   <= 2'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      is_load_q   <= is_load_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign loadData      = load_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign accessError   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the access rules.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        DMemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        busy;
  logic        done;
  logic        accessError;

  int          checks;
  int          errors;
  logic [31:0] modelLoad;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .memRead(memRead),
    .DMemWrite(DMemWrite),
    .funct3(funct3),
    .addr(addr),
    .storeData(storeData),
    .bus(bus),
    .loadData(loadData),
    .busy(busy),
    .done(done),
    .accessError(accessError)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit modelIllegal(input bit isStore, input logic [2:0] f3);
    if (isStore) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3 >= 3'd6);
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int size;
    int mask;
    size = sizeOf(f3);
    mask = ((1 << size) - 1) << int'(a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
    int size;
    size = sizeOf(f3);
    if (size == 1) return (sd % 256) * 32'h01010101;
    if (size == 2) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] modelExtend(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int     size;
    longint v;
    longint span;
    size = sizeOf(f3);
    if (size == 4) return rd;
    v    = longint'(rd >> (8 * (a % 4)));
    span = longint'(1) << (8 * size);
    v    = v % span;
    if (!f3[2] && (v >= span / 2)) v = v - span;
    return v[31:0];
  endfunction

  task automatic applyStimulus(input bit isStore, input bit both, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                               input int waitCycles, input bit inject);
    bit expErr;
    bit timedOut;
    int size;
    int reqCycles;
    int expReq;
    size   = sizeOf(f3);
    expErr = modelIllegal(isStore, f3) || ((a % size) != 0);

    @(negedge clk);
    addr      = a;
    funct3    = f3;
    storeData = sd;
    DMemWrite = isStore;
    memRead   = !isStore || both;
    @(posedge clk);
    @(negedge clk);
    DMemWrite = 1'b0;
    memRead   = 1'b0;

    if (expErr) begin
      checkOutput("err_req", 32'(bus.mem_req), 32'd0);
      checkOutput("err_done", 32'(done), 32'd1);
      checkOutput("err_flag", 32'(accessError), 32'd1);
      checkOutput("err_load", loadData, modelLoad);
    end else begin
      checkOutput("req", 32'(bus.mem_req), 32'd1);
      checkOutput("we", 32'(bus.mem_we), 32'(isStore));
      checkOutput("addr", bus.mem_addr, a & ~32'd3);
      checkOutput("be", 32'(bus.mem_be), 32'(modelBe(f3, a)));
      checkOutput("wdata", bus.mem_wdata, isStore ? modelWdata(f3, sd) : 32'd0);
      checkOutput("busy_req", 32'(busy), 32'd1);
      reqCycles = 0;
      while ((bus.mem_req === 1'b1) && (reqCycles < 64)) begin
        reqCycles++;
        bus.mem_ready = (reqCycles > waitCycles);
        bus.mem_rdata = bus.mem_ready ? rd : $urandom;
        if (inject && (reqCycles == 1)) memRead = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        memRead       = 1'b0;
      end
      timedOut = (waitCycles >= TIMEOUT);
      expReq   = timedOut ? TIMEOUT : waitCycles + 1;
      checkOutput("req_cycles", 32'(reqCycles), 32'(expReq));
      if (!isStore && !timedOut) modelLoad = modelExtend(f3, a, rd);
      checkOutput("done", 32'(done), 32'd1);
      checkOutput("access_err", 32'(accessError), 32'(timedOut));
      checkOutput("load_data", loadData, modelLoad);
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("req_after", 32'(bus.mem_req), 32'd0);
  endtask

  // Main sequence: reset, directed scenarios, randomized accesses, summary.
  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    int          rw;
    bit          rs;

    checks        = 0;
    errors        = 0;
    modelLoad     = 32'd0;
    rst_n         = 1'b0;
    memRead       = 1'b0;
    DMemWrite     = 1'b0;
    funct3        = 3'b0;
    addr          = 32'd0;
    storeData     = 32'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_be", 32'(bus.mem_be), 32'd0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_load", loadData, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(accessError), 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0A, 32'h0000BEEF, 32'h0, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b101, 32'h0A, 32'h0, 32'hBEEF0000, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h12345678, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, TIMEOUT + 4, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 1'b0);

    // Reset in the middle of a waiting load drops it without a done pulse.
    @(negedge clk);
    addr    = 32'h40;
    funct3  = 3'b010;
    memRead = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memRead = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("mid_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    modelLoad = 32'd0;
    checkOutput("mid_rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_load", loadData, 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_done2", 32'(done), 32'd0);
    checkOutput("mid_rst_req2", 32'(bus.mem_req), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom & 32'h00000FFF;
      rw  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
      applyStimulus(rs, 1'b0, rf3, ra, $urandom, $urandom, rw, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
